// File: rtl/fsm_phase_driver.sv
// fsm_phase_driver: command-driven pulse transmitter for a three-phase
// pulse-counting downstream FSM (inputs In1/RST, output Out1).
// Keeps a shadow of the downstream phase, sends the fewest In1 pulses that
// reach a requested phase, resynchronises the downstream through its RST,
// and latches any disagreement between Out1 and the shadow phase.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_SYNC  | ds_rst high for one cycle; clears shadow phase and mismatch
// S_IDLE  | cmd_ready high; waiting for a command
// S_PULSE | drv_out high for one cycle; shadow phase advances at its end
// S_GAP   | drv_out low for PULSE_GAP cycles between pulses
// S_DONE  | done high for one cycle
module fsm_phase_driver #(
    parameter int unsigned PULSE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_phase_i,
    output logic       cmd_ready_o,
    output logic       drv_out_o,
    output logic       ds_rst_o,
    input  logic       fb_level_i,
    output logic [1:0] phase_o,
    output logic       done_o,
    output logic       mismatch_o
);

    localparam int unsigned GW = 4;
    // Gap counter counts down from PULSE_GAP-1 to 0, one GAP cycle per value.
    localparam logic [GW-1:0] GAP_LOAD = (PULSE_GAP > 0) ? GW'(PULSE_GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          resync_q;   // SYNC was entered by a command, so it ends in DONE
    logic [1:0]    rem_q;
    logic [GW-1:0] gap_q;
    logic          ready_q;
    logic          drv_q;
    logic          ds_rst_q;
    logic [1:0]    phase_q;
    logic          done_q;
    logic          mm_q;

    logic [2:0]    diff_d;
    logic [1:0]    rem_d;
    logic [1:0]    phase_inc_d;
    logic          fb_bad_d;
    logic          accept_d;

    // Forward distance to the requested phase, next shadow phase, feedback compare.
    always_comb begin
        diff_d      = {1'b0, cmd_phase_i} + 3'd3 - {1'b0, phase_q};
        rem_d       = (diff_d >= 3'd3) ? 2'(diff_d - 3'd3) : diff_d[1:0];
        phase_inc_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        fb_bad_d    = fb_level_i != (phase_q == 2'd2);
        accept_d    = cmd_valid_i && ready_q;
    end

    // Sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SYNC;
            resync_q <= 1'b0;
            rem_q    <= 2'd0;
            gap_q    <= '0;
            ready_q  <= 1'b0;
            drv_q    <= 1'b0;
            ds_rst_q <= 1'b1;
            phase_q  <= 2'd0;
            done_q   <= 1'b0;
            mm_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    ds_rst_q <= 1'b0;
                    phase_q  <= 2'd0;
                    mm_q     <= 1'b0;
                    resync_q <= 1'b0;
                    if (resync_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (fb_bad_d) begin
                        mm_q <= 1'b1;
                    end
                    if (accept_d) begin
                        ready_q <= 1'b0;
                        if (cmd_phase_i == 2'd3) begin
                            state_q  <= S_SYNC;
                            resync_q <= 1'b1;
                            ds_rst_q <= 1'b1;
                        end else if (rem_d == 2'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_PULSE;
                            drv_q   <= 1'b1;
                            rem_q   <= rem_d;
                        end
                    end
                end
                S_PULSE: begin
                    phase_q <= phase_inc_d;
                    rem_q   <= rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_q <= S_DONE;
                        drv_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (PULSE_GAP == 0) begin
                        drv_q <= 1'b1;
                    end else begin
                        state_q <= S_GAP;
                        drv_q   <= 1'b0;
                        gap_q   <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_PULSE;
                        drv_q   <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (fb_bad_d) begin
                        mm_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_SYNC;
                    ds_rst_q <= 1'b1;
                    drv_q    <= 1'b0;
                    ready_q  <= 1'b0;
                    resync_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign drv_out_o   = drv_q;
    assign ds_rst_o    = ds_rst_q;
    assign phase_o     = phase_q;
    assign done_o      = done_q;
    assign mismatch_o  = mm_q;

endmodule
